// File: rtl/div_freq_meter.sv
// Gated-window frequency meter for a divided clock on the reference clock:
// counts rising edges and tracks the shortest/longest rise-to-rise interval.
module div_freq_meter #(
    parameter int CNT_W    = 32,
    parameter int PER_W    = 16,
    parameter int GATE_LEN = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             div_in,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [PER_W-1:0] min_per,
    output logic [PER_W-1:0] max_per,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS
    } state_t;

    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_LEN);
    localparam logic [PER_W-1:0] PER_MAX   = '1;

    state_t           state;
    state_t           state_next;
    logic             div_d;
    logic             rise;
    logic             window_end;
    logic [CNT_W-1:0] gate_cnt;
    logic [CNT_W-1:0] work_cnt;
    logic [PER_W-1:0] work_min;
    logic [PER_W-1:0] work_max;
    logic [PER_W-1:0] per_cnt;
    logic [CNT_W-1:0] cnt_upd;
    logic [PER_W-1:0] min_upd;
    logic [PER_W-1:0] max_upd;

    assign rise       = div_in & ~div_d;
    assign window_end = (state == MEAS) && (gate_cnt == GATE_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = ARM;
            end
            ARM: begin
                busy = 1'b1;
                if (rise) state_next = MEAS;
            end
            MEAS: begin
                busy = 1'b1;
                if (window_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Working values including the current cycle's rise, so the final
    // window cycle is folded into the latched results.
    always_comb begin
        cnt_upd = work_cnt;
        min_upd = work_min;
        max_upd = work_max;
        if (rise) begin
            cnt_upd = work_cnt + CNT_W'(1);
            if (per_cnt < work_min) min_upd = per_cnt;
            if (per_cnt > work_max) max_upd = per_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_d    <= 1'b0;
            gate_cnt <= '0;
            work_cnt <= '0;
            work_min <= '0;
            work_max <= '0;
            per_cnt  <= '0;
            edge_cnt <= '0;
            min_per  <= '0;
            max_per  <= '0;
            done     <= 1'b0;
        end else begin
            div_d <= div_in;
            done  <= 1'b0;
            case (state)
                ARM: begin
                    // Arming edge: the next cycle is both window cycle 1 and
                    // one cycle after the interval reference.
                    if (rise) begin
                        gate_cnt <= CNT_W'(1);
                        per_cnt  <= PER_W'(1);
                        work_cnt <= '0;
                        work_min <= PER_MAX;
                        work_max <= '0;
                    end
                end
                MEAS: begin
                    work_cnt <= cnt_upd;
                    work_min <= min_upd;
                    work_max <= max_upd;
                    gate_cnt <= gate_cnt + CNT_W'(1);
                    if (rise) begin
                        per_cnt <= PER_W'(1);
                    end else if (per_cnt != PER_MAX) begin
                        per_cnt <= per_cnt + PER_W'(1);
                    end
                    if (window_end) begin
                        edge_cnt <= cnt_upd;
                        min_per  <= min_upd;
                        max_per  <= max_upd;
                        done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
